adder_nbit_seq: RTL and testbench
=================================

ADDER_NBIT_SEQ -- requirements
Module: adder_nbit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  request to start one operation.
REQ-006 SHALL have port i_sub  input  1  0 selects add, 1 selects subtract.
REQ-007 SHALL have port i_a  input  WIDTH  operand A.
REQ-008 SHALL have port i_b  input  WIDTH  operand B.
REQ-009 SHALL have port i_cin  input  1  carry-in for add, borrow-in for subtract.
REQ-010 SHALL have port o_busy  output  1  an operation is in progress.
REQ-011 SHALL have port o_done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have port o_sum  output  WIDTH  result.
REQ-013 SHALL have port o_cout  output  1  carry-out (add) or not-borrow (subtract).
REQ-014 SHALL have port o_ovf  output  1  signed overflow flag.

Function
REQ-015 SHALL reject elaboration unless WIDTH % CHUNK == 0 and CHUNK >= 1; N = WIDTH/CHUNK.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL accept i_start only when o_busy == 0 (IDLE or DONE); it SHALL latch i_a, i_b, i_sub, i_cin at that edge, clear the chunk index, and go to RUN.
REQ-018 SHALL ignore i_start and any operand changes while in RUN.
REQ-019 SHALL, in add mode, compute {cout,sum} = A + B + cin (WIDTH+1 bits, modulo 2^(WIDTH+1)).
REQ-020 SHALL, in subtract mode, compute A + ~B + !cin, so that sum = A - B - cin mod 2^WIDTH and cout = 1 iff no borrow.
REQ-021 SHALL process chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK), LSB chunk first, in one RUN cycle each, passing the registered carry to the next chunk.
REQ-022 SHALL leave RUN after exactly N cycles and enter DONE; o_done SHALL be 1 only in DONE; the next state after DONE SHALL be IDLE, or RUN if i_start is 1.
REQ-023 SHALL assert o_done exactly N+1 rising edges after the edge that accepted i_start.
REQ-024 SHALL hold o_sum, o_cout, o_ovf stable from DONE until the next accepted start completes; the outputs are undefined during RUN.
REQ-025 SHALL drive o_busy = 1 in RUN only.

Reset
REQ-026 SHALL, on any edge with i_rst = 1, enter IDLE and clear o_busy, o_done, o_sum, o_cout, and o_ovf to 0, including when reset arrives in the middle of RUN.
REQ-027 SHALL give i_rst priority over i_start on the same edge.

Configuration
REQ-028 SHALL, with ADDER_SEQ_OVF_EN defined, set o_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the effective B operand (inverted in subtract mode).
REQ-029 SHALL, without ADDER_SEQ_OVF_EN, tie o_ovf to 0 and instantiate no overflow logic.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH/CHUNK constants in the shared package adder_pkg.
REQ-031 SHALL use one sub-module, adder_chunk: a combinational CHUNK-bit ripple adder with ports a, b, cin, sum, cout, instantiated once and reused each cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-032 SHALL cover: add with A=0xFFFF, B=0x0001, cin=0 -> o_sum=0x0000, o_cout=1, o_done 5 edges after start, busy for 4 cycles.
REQ-033 SHALL cover: subtract with A=0x0005, B=0x0007, cin=0 -> o_sum=0xFFFE, o_cout=0, o_ovf=0.
REQ-034 SHALL cover: add with A=0x7FFF, B=0x0001, cin=0 -> o_sum=0x8000, o_cout=0, and o_ovf=1 with the macro defined or 0 without it.
REQ-035 SHALL cover: i_start pulsed with new operands mid-RUN -> first result unaffected, no extra o_done; a back-to-back start in DONE -> second o_done 5 edges later.
REQ-036 SHALL cover: i_rst asserted in the 2nd RUN cycle -> all outputs 0 and IDLE next edge, with no o_done.
REQ-037 SHALL cover: 1000 random operations checked against a reference model of A+B+cin or A-B-cin (WIDTH+1 bits), stopping on the first mismatch.

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the chunk-serial adder/subtractor (adder_nbit_seq).
//   - DEFAULT_WIDTH / DEFAULT_CHUNK : default operand width and bits per cycle
//   - state_e                       : FSM state encoding (IDLE, RUN, DONE)
// No ports (package).
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : adder_pkg

// File: rtl/adder_nbit_seq_if.sv
// -----------------------------------------------------------------------------
// adder_nbit_seq_if
// Bundles the request/result signals of adder_nbit_seq.
// Handshake: the master raises start for one or more cycles with operands
// valid; a start is taken on a rising edge only while busy == 0. The result
// (sum/cout/ovf) is valid in the cycle where done == 1 and is held until the
// next accepted operation completes.
//   master : drives start, sub, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : the reverse directions
// -----------------------------------------------------------------------------
interface adder_nbit_seq_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );

endinterface : adder_nbit_seq_if

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Purely combinational CHUNK-bit ripple-carry adder.
// Ports:
//   a, b  [CHUNK-1:0] in  : addends
//   cin              in  : carry in
//   sum  [CHUNK-1:0] out : a + b + cin (low CHUNK bits)
//   cout             out : carry out of the top bit
// -----------------------------------------------------------------------------
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[CHUNK];
    end

endmodule : adder_chunk

// File: rtl/adder_nbit_seq.sv
// -----------------------------------------------------------------------------
// adder_nbit_seq
// Chunk-serial WIDTH-bit adder/subtractor. One CHUNK-bit slice is added per
// clock, LSB slice first, with the carry kept in a flop between slices, so an
// operation spends exactly N = WIDTH/CHUNK cycles in RUN followed by one DONE
// cycle in which o_done pulses.
// Optional feature: define ADDER_SEQ_OVF_EN to build the signed-overflow flag;
// otherwise o_ovf is tied to 0.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : start request, taken only while o_busy == 0
//   i_sub               : 0 add, 1 subtract
//   i_a, i_b [WIDTH]    : operands
//   i_cin               : carry-in (add) / borrow-in (subtract)
//   o_busy              : operation in progress (RUN)
//   o_done              : one-cycle result-valid pulse (DONE)
//   o_sum [WIDTH]       : result
//   o_cout              : carry-out (add) / not-borrow (subtract)
//   o_ovf               : signed overflow
// -----------------------------------------------------------------------------
module adder_nbit_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    // Guard against a CHUNK of zero before dividing.
    localparam int N     = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam int MSB   = WIDTH - 1;

    if (CHUNK < 1) begin : g_bad_chunk
        $error("adder_nbit_seq: CHUNK must be >= 1");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("adder_nbit_seq: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // effective B (already inverted for subtract)
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             accept;
    logic             run_last;
    int               chunk_lsb;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    // A start is only taken while not busy; RUN ignores i_start entirely.
    assign accept   = i_start && (state_q != RUN);
    assign run_last = (state_q == RUN) && (idx_q == LAST_IDX);

    // ---------------- chunk datapath ----------------
    always_comb begin
        chunk_lsb = int'(idx_q) * CHUNK;
        chunk_a   = a_q[chunk_lsb +: CHUNK];
        chunk_b   = b_q[chunk_lsb +: CHUNK];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = i_start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy = (state_q == RUN);
        o_done = (state_q == DONE);
    end

    // ---------------- datapath next values ----------------
    // Subtract is A + ~B + !cin: B and the carry are inverted once at accept
    // so the RUN cycles are identical for both modes.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        if (accept) begin
            a_d     = i_a;
            b_d     = i_sub ? ~i_b : i_b;
            carry_d = i_sub ? ~i_cin : i_cin;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            sum_d[chunk_lsb +: CHUNK] = chunk_sum;
            carry_d = chunk_cout;
            if (run_last) begin
                cout_d = chunk_cout;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign o_sum  = sum_q;
    assign o_cout = cout_q;

    // ---------------- optional signed overflow ----------------
`ifdef ADDER_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Operands of equal sign whose result sign differs; the result MSB comes
    // straight from the top chunk in its final RUN cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (run_last) begin
            ovf_d = (a_q[MSB] == b_q[MSB]) && (chunk_sum[CHUNK-1] != a_q[MSB]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

endmodule : adder_nbit_seq

// File: tb/tb_adder_nbit_seq.sv
// -----------------------------------------------------------------------------
// tb_adder_nbit_seq
// Self-checking bench for adder_nbit_seq (WIDTH=16, CHUNK=4). Expected results
// ({ovf, cout, sum}) are pushed to exp_q when an operation is started and
// popped when o_done is seen. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_adder_nbit_seq;
    import adder_pkg::*;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    adder_nbit_seq_if #(.WIDTH(W)) bus ();

    adder_nbit_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (bus.start),
        .i_sub   (bus.sub),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .i_cin   (bus.cin),
        .o_busy  (bus.busy),
        .o_done  (bus.done),
        .o_sum   (bus.sum),
        .o_cout  (bus.cout),
        .o_ovf   (bus.ovf)
    );

    // Reference: plain arithmetic on WIDTH+1 bits, signed overflow from the
    // two's-complement operand/result signs.
    function automatic logic [W+1:0] model(input logic sub, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
        logic [W:0] r;
        logic       cout;
        logic       ovf;
        if (!sub) begin
            r    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            cout = r[W];
            ovf  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
            cout = ~r[W];
            ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
`ifndef ADDER_SEQ_OVF_EN
        ovf = 1'b0;
`endif
        return {ovf, cout, r[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Returns at the falling edge just after the accepting rising edge.
    task automatic drive_start(input logic sub, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = sub;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        exp_q.push_back(model(sub, a, b, cin));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts rising edges since the accepting edge (already 1 on entry) until
    // o_done is seen, bounded at 20.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 1;
        busy_cycles = bus.busy ? 1 : 0;
        while (!bus.done && edges < 20) begin
            @(negedge clk);
            edges++;
            if (bus.busy) busy_cycles++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;   // reset must win over a simultaneous start
        bus.sub   = 1'b0;
        bus.a     = 16'h1234;
        bus.b     = 16'h4321;
        bus.cin   = 1'b1;
        idle_cycles(3);
        n_checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_add_carry();
        int edges, busy_cycles;
        logic [W+1:0] exp;
        drive_start(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_done(edges, busy_cycles);
        exp = exp_q.pop_front();
        n_checks++;
        if (edges !== N + 1) begin
            n_fail++;
            $display("FAIL add_latency: done after %0d edges, required %0d", edges, N + 1);
        end
        n_checks++;
        if (busy_cycles !== N) begin
            n_fail++;
            $display("FAIL add_busy: busy %0d cycles, required %0d", busy_cycles, N);
        end
        n_checks++;
        if ({bus.ovf, bus.cout, bus.sum} !== exp || bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL add_carry: got ovf=%b cout=%b sum=%h, required ovf=%b cout=1 sum=0000",
                     bus.ovf, bus.cout, bus.sum, exp[W+1]);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL add_hold: done=%b sum=%h cout=%b, required done=0 sum=0000 cout=1",
                     bus.done, bus.sum, bus.cout);
        end
    endtask

    task automatic test_sub();
        int edges, busy_cycles;
        logic [W+1:0] exp;
        drive_start(1'b1, 16'h0005, 16'h0007, 1'b0);
        wait_done(edges, busy_cycles);
        exp = exp_q.pop_front();
        n_checks++;
        if (edges !== N + 1 || {bus.ovf, bus.cout, bus.sum} !== exp
            || bus.sum !== 16'hFFFE || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: edges=%0d ovf=%b cout=%b sum=%h, required edges=%0d ovf=0 cout=0 sum=fffe",
                     edges, bus.ovf, bus.cout, bus.sum, N + 1);
        end
    endtask

    task automatic test_ovf();
        int edges, busy_cycles;
        logic [W+1:0] exp;
        logic exp_ovf;
`ifdef ADDER_SEQ_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        drive_start(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(edges, busy_cycles);
        exp = exp_q.pop_front();
        n_checks++;
        if (edges !== N + 1 || {bus.ovf, bus.cout, bus.sum} !== exp
            || bus.sum !== 16'h8000 || bus.cout !== 1'b0 || bus.ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL add_ovf: edges=%0d ovf=%b cout=%b sum=%h, required ovf=%b cout=0 sum=8000",
                     edges, bus.ovf, bus.cout, bus.sum, exp_ovf);
        end
    endtask

    // A few fixed corners that exercise carry/borrow-in and chunk boundaries.
    task automatic test_table();
        logic [W*2+1:0] tbl [6];
        int edges, busy_cycles;
        logic [W+1:0] exp;
        tbl[0] = {1'b0, 1'b1, 16'h000F, 16'h0000};   // carry-in ripples across a chunk
        tbl[1] = {1'b1, 1'b1, 16'h0000, 16'h0000};   // 0 - 0 - 1
        tbl[2] = {1'b1, 1'b0, 16'h8000, 16'h0001};   // signed overflow on subtract
        tbl[3] = {1'b0, 1'b1, 16'hFFFF, 16'hFFFF};
        tbl[4] = {1'b1, 1'b1, 16'h1234, 16'h1233};   // exact zero via borrow-in
        tbl[5] = {1'b0, 1'b0, 16'h0F0F, 16'hF0F1};
        foreach (tbl[i]) begin
            drive_start(tbl[i][2*W+1], tbl[i][2*W-1:W], tbl[i][W-1:0], tbl[i][2*W]);
            wait_done(edges, busy_cycles);
            exp = exp_q.pop_front();
            n_checks++;
            if (edges !== N + 1 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
                n_fail++;
                $display("FAIL table_%0d: edges=%0d {ovf,cout,sum}=%h, required edges=%0d %h",
                         i, edges, {bus.ovf, bus.cout, bus.sum}, N + 1, exp);
            end
        end
    endtask

    task automatic test_mid_run_start();
        int edges, dones;
        logic [W+1:0] exp;
        drive_start(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);                 // second RUN cycle
        bus.start = 1'b1;
        bus.sub   = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        edges = 3;
        while (!bus.done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (edges !== N + 1 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
            n_fail++;
            $display("FAIL mid_run_result: edges=%0d {ovf,cout,sum}=%h, required edges=%0d %h",
                     edges, {bus.ovf, bus.cout, bus.sum}, N + 1, exp);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_checks++;
        if (dones !== 0 || bus.sum !== exp[W-1:0]) begin
            n_fail++;
            $display("FAIL mid_run_extra_done: extra dones=%0d sum=%h, required 0 and %h",
                     dones, bus.sum, exp[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int edges, busy_cycles;
        logic [W+1:0] exp;
        drive_start(1'b0, 16'h0123, 16'h0456, 1'b1);
        wait_done(edges, busy_cycles);
        exp = exp_q.pop_front();
        n_checks++;
        if (edges !== N + 1 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: edges=%0d {ovf,cout,sum}=%h, required edges=%0d %h",
                     edges, {bus.ovf, bus.cout, bus.sum}, N + 1, exp);
        end
        // Still in DONE here: start the next operation immediately.
        bus.start = 1'b1;
        bus.sub   = 1'b1;
        bus.a     = 16'h8000;
        bus.b     = 16'h7FFF;
        bus.cin   = 1'b0;
        exp_q.push_back(model(1'b1, 16'h8000, 16'h7FFF, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(edges, busy_cycles);
        exp = exp_q.pop_front();
        n_checks++;
        if (edges !== N + 1 || busy_cycles !== N || {bus.ovf, bus.cout, bus.sum} !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: edges=%0d busy=%0d {ovf,cout,sum}=%h, required edges=%0d busy=%0d %h",
                     edges, busy_cycles, {bus.ovf, bus.cout, bus.sum}, N + 1, N, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        logic [W+1:0] discard;
        drive_start(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);                 // second RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        discard = exp_q.pop_front();
        n_checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b ovf=%b (dropped %h), required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, discard);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_run_idle: %0d cycles with busy/done, required 0", dones);
        end
    endtask

    task automatic test_random();
        int edges, busy_cycles;
        logic [W+1:0] exp;
        logic         sub, cin;
        logic [W-1:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            a   = W'($urandom_range(0, 65535));
            b   = W'($urandom_range(0, 65535));
            drive_start(sub, a, b, cin);
            wait_done(edges, busy_cycles);
            exp = exp_q.pop_front();
            n_checks++;
            if (edges !== N + 1 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: sub=%b a=%h b=%h cin=%b edges=%0d {ovf,cout,sum}=%h, required edges=%0d %h",
                         i, sub, a, b, cin, edges, {bus.ovf, bus.cout, bus.sum}, N + 1, exp);
                break;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        test_reset();
        test_add_carry();
        test_sub();
        test_ovf();
        test_table();
        test_mid_run_start();
        test_back_to_back();
        idle_cycles(2);
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_nbit_seq
